// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Merges the CPU core's instruction and data sram-like master ports onto a
// single sram-like port towards the memory bridge/cache. Every accepted
// request pushes its requester (0=inst, 1=data) into an in-order ID FIFO.
// Each downstream data_ok pops the FIFO head and is routed back to the
// requester that issued the transaction.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inst_req/inst_addr    instruction fetch request (always a word read)
//   inst_addr_ok          instruction request accepted this cycle
//   inst_data_ok/rdata    instruction read data return
//   data_req/wr/size/addr/wdata   data request (read or write)
//   data_addr_ok          data request accepted this cycle
//   data_data_ok/rdata    data read return / write completion
//   mem_req/wr/size/addr/wdata    merged request towards memory
//   mem_addr_ok           downstream accepted the merged request
//   mem_data_ok/rdata     downstream response
//
// Parameter:
//   OUTSTANDING  maximum accepted-but-unanswered transactions (power of 2, >=2)
// -----------------------------------------------------------------------------
module cpu_mem_arbiter #(
   parameter int OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int PTR_W = $clog2(OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   lock_state_t            lock_state;
   logic                   locked_sel;

   logic [OUTSTANDING-1:0] order_q;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;

   logic full;
   logic empty;
   logic sel;
   logic sel_req;
   logic accept;
   logic pop;
   logic head;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Once a request has been presented and stalled, the same requester
   // keeps the port until it is accepted, so the downstream sees a stable
   // request. Otherwise data wins: it belongs to an older instruction.
   assign sel     = (lock_state == LOCKED) ? locked_sel : data_req;
   assign sel_req = sel ? data_req : inst_req;

   assign mem_req   = ~rst & ~full & sel_req;
   assign mem_wr    = sel ? data_wr    : 1'b0;
   assign mem_size  = sel ? data_size  : 2'd2;
   assign mem_addr  = sel ? data_addr  : inst_addr;
   assign mem_wdata = sel ? data_wdata : 32'd0;

   assign accept       = mem_req & mem_addr_ok;
   assign inst_addr_ok = accept & ~sel;
   assign data_addr_ok = accept &  sel;

   // A response with nothing outstanding is stray and is dropped.
   assign pop  = ~rst & mem_data_ok & ~empty;
   assign head = order_q[rd_ptr];

   assign inst_data_ok = pop & ~head;
   assign data_data_ok = pop &  head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Lock FSM. A locked requester that withdraws its request releases the
   // lock so the other side is not starved.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_state <= UNLOCKED;
         locked_sel <= 1'b0;
      end else begin
         case (lock_state)
            UNLOCKED: begin
               if (mem_req && !mem_addr_ok) begin
                  lock_state <= LOCKED;
                  locked_sel <= sel;
               end
            end
            LOCKED: begin
               if (accept || !sel_req) begin
                  lock_state <= UNLOCKED;
               end
            end
            default: lock_state <= UNLOCKED;
         endcase
      end
   end

   // Order FIFO control. Pointers wrap naturally at OUTSTANDING.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Order FIFO storage; only meaningful under count, so no reset.
   always_ff @(posedge clk) begin
      if (accept) order_q[wr_ptr] <= sel;
   end

endmodule
